// File: rtl/probe_enq_monitor.sv
// probe_enq_monitor: per-slice L2 probe-queue enqueue monitor that classifies waits and stalls
// and streams the resulting event records through a small round-robin-fed FIFO.
module probe_enq_monitor #(
  parameter int NUM_SLICES = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SLICES-1:0]         enq_valid,
  input  logic [NUM_SLICES-1:0]         enq_ready,
  input  logic                          clear,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(NUM_SLICES)-1:0] evt_slice,
  output logic [1:0]                    evt_kind,
  output logic [CNT_W-1:0]              evt_wait,
  output logic                          stall_err,
  output logic                          timeout_err,
  output logic                          ovf_err,
  output logic [31:0]                   fire_cnt
);
  localparam int SW  = $clog2(NUM_SLICES);
  localparam int SW1 = SW + 1;
  localparam int AW  = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int AW1 = AW + 1;
  localparam int EW  = SW + 2 + CNT_W;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_STARVED = 2'd2;
  localparam logic [1:0] K_STALL = 2'd0, K_DROP = 2'd1, K_TIMEOUT = 2'd2, K_FIRE = 2'd3;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic [NUM_SLICES-1:0] prev_q, pend_q, pend_d, ev, lost, fire, taken;
  logic [1:0]       st_q [NUM_SLICES];
  logic [1:0]       st_d [NUM_SLICES];
  logic [CNT_W-1:0] cnt_q [NUM_SLICES];
  logic [CNT_W-1:0] cnt_d [NUM_SLICES];
  logic [1:0]       ev_kind [NUM_SLICES];
  logic [CNT_W-1:0] ev_wait [NUM_SLICES];
  logic [1:0]       pk_q [NUM_SLICES];
  logic [1:0]       pk_d [NUM_SLICES];
  logic [CNT_W-1:0] pw_q [NUM_SLICES];
  logic [CNT_W-1:0] pw_d [NUM_SLICES];
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [SW-1:0]    rr_q, rr_d, gnt_idx;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      fcnt_q, fcnt_d;
  logic [SW:0]      fires;
  logic [32:0]      fire_sum;
  logic [31:0]      fire_cnt_q, fire_cnt_d;
  logic stall_err_q, stall_err_d, timeout_err_q, timeout_err_d, ovf_err_q, ovf_err_d;
  logic gnt, hit, pop, stall_hit, tmo_hit;

  always_comb begin
    for (int i = 0; i < NUM_SLICES; i++) begin
      fire[i] = enq_valid[i] & enq_ready[i];
      st_d[i] = st_q[i];
      cnt_d[i] = cnt_q[i];
      ev[i] = 1'b0;
      ev_kind[i] = K_STALL;
      ev_wait[i] = '0;
      if (st_q[i] == S_IDLE) begin
        if (enq_valid[i] && !enq_ready[i]) begin
          st_d[i] = S_WAIT;
          cnt_d[i] = CNT_W'(1);
          ev[i] = ~prev_q[i];
        end
      end else if (!enq_valid[i] || enq_ready[i]) begin
        ev[i] = 1'b1;
        ev_kind[i] = enq_valid[i] ? K_FIRE : K_DROP;
        ev_wait[i] = cnt_q[i];
        st_d[i] = S_IDLE;
        cnt_d[i] = '0;
      end else if (st_q[i] == S_WAIT) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (cnt_d[i] == TMO) begin
          ev[i] = 1'b1;
          ev_kind[i] = K_TIMEOUT;
          ev_wait[i] = TMO;
          st_d[i] = S_STARVED;
        end
      end else begin
        cnt_d[i] = &cnt_q[i] ? cnt_q[i] : cnt_q[i] + 1'b1;
      end
    end
  end

  // Scan downward so the pending slice closest after rr_q is the one left in gnt_idx.
  always_comb begin
    pop = evt_valid & evt_ready;
    hit = 1'b0;
    gnt_idx = '0;
    for (int j = NUM_SLICES - 1; j >= 0; j--) begin
      if (pend_q[rr_q + SW'(j)]) begin
        hit = 1'b1;
        gnt_idx = rr_q + SW'(j);
      end
    end
    gnt = hit & (fcnt_q != AW1'(FIFO_DEPTH) | pop);
  end

  always_comb begin
    stall_hit = 1'b0;
    tmo_hit = 1'b0;
    fires = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      taken[i] = gnt && gnt_idx == SW'(i);
      lost[i] = ev[i] & pend_q[i] & ~taken[i];
      pend_d[i] = ev[i] | (pend_q[i] & ~taken[i]);
      pk_d[i] = ev[i] && !lost[i] ? ev_kind[i] : pk_q[i];
      pw_d[i] = ev[i] && !lost[i] ? ev_wait[i] : pw_q[i];
      stall_hit = stall_hit | (ev[i] && ev_kind[i] == K_STALL);
      tmo_hit = tmo_hit | (ev[i] && ev_kind[i] == K_TIMEOUT);
      fires = fires + SW1'(fire[i]);
    end
    rr_d = gnt ? gnt_idx + 1'b1 : rr_q;
    wr_d = gnt ? (wr_q == AW'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? (rd_q == AW'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    fcnt_d = fcnt_q + AW1'(gnt) - AW1'(pop);
    fire_sum = {1'b0, fire_cnt_q} + 33'(fires);
    fire_cnt_d = clear ? '0 : fire_sum[32] ? '1 : fire_sum[31:0];
    stall_err_d = ~clear & (stall_err_q | stall_hit);
    timeout_err_d = ~clear & (timeout_err_q | tmo_hit);
    ovf_err_d = ~clear & (ovf_err_q | |lost);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      pend_q <= '0;
      rr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      fcnt_q <= '0;
      fire_cnt_q <= '0;
      stall_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
      for (int i = 0; i < NUM_SLICES; i++) begin
        st_q[i] <= S_IDLE;
        cnt_q[i] <= '0;
        pk_q[i] <= '0;
        pw_q[i] <= '0;
      end
    end else begin
      prev_q <= enq_valid;
      pend_q <= pend_d;
      rr_q <= rr_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      fcnt_q <= fcnt_d;
      fire_cnt_q <= fire_cnt_d;
      stall_err_q <= stall_err_d;
      timeout_err_q <= timeout_err_d;
      ovf_err_q <= ovf_err_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      pk_q <= pk_d;
      pw_q <= pw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) mem_q[wr_q] <= {gnt_idx, pk_q[gnt_idx], pw_q[gnt_idx]};
  end

  assign evt_valid = fcnt_q != '0;
  assign {evt_slice, evt_kind, evt_wait} = evt_valid ? mem_q[rd_q] : '0;
  assign stall_err = stall_err_q;
  assign timeout_err = timeout_err_q;
  assign ovf_err = ovf_err_q;
  assign fire_cnt = fire_cnt_q;
endmodule

// File: tb/tb_probe_enq_monitor.sv
// tb_probe_enq_monitor: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_probe_enq_monitor;
  localparam int NS = 4, TMO = 256, CW = 16, FD = 4;
  logic clk = 0, rst = 1, clear = 0, evt_ready = 0;
  logic [3:0] enq_valid = '0, enq_ready = '0;
  logic evt_valid, stall_err, timeout_err, ovf_err;
  logic [1:0] evt_slice, evt_kind;
  logic [15:0] evt_wait;
  logic [31:0] fire_cnt;
  int errors = 0, checks = 0;

  typedef struct {int s; int k; int w;} ev_t;
  ev_t m_fifo[$];
  ev_t m_pe[NS];
  ev_t ne;
  int m_st[NS], m_cnt[NS], m_rr, g, nf;
  bit m_prev[NS], m_pv[NS], nh, mv, mr, pop, m_stall, m_tmo, m_ovf, s_set, t_set, o_set;
  longint m_fire;

  always #5 clk = ~clk;

  probe_enq_monitor #(.NUM_SLICES(NS), .TIMEOUT(TMO), .CNT_W(CW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready), .clear(clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_slice(evt_slice), .evt_kind(evt_kind),
    .evt_wait(evt_wait), .stall_err(stall_err), .timeout_err(timeout_err), .ovf_err(ovf_err),
    .fire_cnt(fire_cnt));

  // Reference model: slice waits as plain integers, pending slots as one-deep holders, FIFO as a queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_rr = 0; m_stall = 0; m_tmo = 0; m_ovf = 0; m_fire = 0;
      for (int i = 0; i < NS; i++) begin
        m_st[i] = 0; m_cnt[i] = 0; m_prev[i] = 0; m_pv[i] = 0;
      end
    end else begin
      pop = m_fifo.size() > 0 && evt_ready;
      g = -1;
      if (m_fifo.size() < FD || pop)
        for (int j = 0; j < NS && g < 0; j++) if (m_pv[(m_rr + j) % NS]) g = (m_rr + j) % NS;
      if (pop) void'(m_fifo.pop_front());
      if (g >= 0) begin
        m_fifo.push_back(m_pe[g]);
        m_pv[g] = 0;
        m_rr = (g + 1) % NS;
      end
      nf = 0; s_set = 0; t_set = 0; o_set = 0;
      for (int i = 0; i < NS; i++) begin
        mv = enq_valid[i]; mr = enq_ready[i]; nh = 0;
        if (mv && mr) nf++;
        if (m_st[i] == 0) begin
          if (mv && !mr) begin
            m_st[i] = 1; m_cnt[i] = 1;
            if (!m_prev[i]) begin nh = 1; ne = '{i, 0, 0}; end
          end
        end else if (!mv || mr) begin
          nh = 1; ne = '{i, mv ? 3 : 1, m_cnt[i]};
          m_st[i] = 0; m_cnt[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] < 65535 ? m_cnt[i] + 1 : 65535;
          if (m_st[i] == 1 && m_cnt[i] == TMO) begin nh = 1; ne = '{i, 2, TMO}; m_st[i] = 2; end
        end
        m_prev[i] = mv;
        if (nh) begin
          if (ne.k == 0) s_set = 1;
          if (ne.k == 2) t_set = 1;
          if (m_pv[i]) o_set = 1;
          else begin m_pv[i] = 1; m_pe[i] = ne; end
        end
      end
      if (clear) begin
        m_stall = 0; m_tmo = 0; m_ovf = 0; m_fire = 0;
      end else begin
        m_stall |= s_set; m_tmo |= t_set; m_ovf |= o_set;
        m_fire = m_fire + nf > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_fire + nf;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; enq_valid = '0; enq_ready = '0; clear = 0; evt_ready = 0;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; enq_valid = '1; enq_ready = 4'b0101; evt_ready = 1;
    tick(); tick();
    checks++;
    if ({evt_valid, evt_slice, evt_kind, evt_wait} !== 21'd0) begin
      errors++; $display("FAIL reset_evt got=%h exp=0", {evt_valid, evt_slice, evt_kind, evt_wait});
    end
    checks++;
    if ({stall_err, timeout_err, ovf_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {stall_err, timeout_err, ovf_err});
    end
    checks++;
    if (fire_cnt !== 32'd0) begin errors++; $display("FAIL reset_fire_cnt got=%0d exp=0", fire_cnt); end
    enq_valid = '0; enq_ready = '0; rst = 0;
    tick();
  endtask

  task automatic test_stall_fire();
    do_reset();
    evt_ready = 1; enq_valid = 4'b0100; enq_ready = '0;
    tick();
    checks++;
    if ({evt_valid, stall_err} !== 2'b01) begin
      errors++; $display("FAIL stall_t1 got valid,stall=%b exp=01", {evt_valid, stall_err});
    end
    tick();
    checks++;
    if ({evt_valid, evt_slice, evt_kind, evt_wait} !== {1'b1, 2'd2, 2'd0, 16'd0}) begin
      errors++; $display("FAIL stall_evt got=%h exp=%h", {evt_valid, evt_slice, evt_kind, evt_wait}, {1'b1, 2'd2, 2'd0, 16'd0});
    end
    tick();
    enq_ready = 4'b0100;
    tick();
    checks++;
    if ({evt_valid, fire_cnt} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL stall_fire_cnt got valid=%b cnt=%0d exp valid=0 cnt=1", evt_valid, fire_cnt);
    end
    enq_valid = '0; enq_ready = '0;
    tick();
    checks++;
    if ({evt_valid, evt_slice, evt_kind, evt_wait} !== {1'b1, 2'd2, 2'd3, 16'd3}) begin
      errors++; $display("FAIL fire_after_wait got=%h exp=%h", {evt_valid, evt_slice, evt_kind, evt_wait}, {1'b1, 2'd2, 2'd3, 16'd3});
    end
  endtask

  task automatic test_all_fire();
    do_reset();
    evt_ready = 1; enq_valid = 4'hF; enq_ready = 4'hF;
    tick();
    checks++;
    if (fire_cnt !== 32'd4) begin errors++; $display("FAIL all_fire_cnt got=%0d exp=4", fire_cnt); end
    enq_valid = '0; enq_ready = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL all_fire_no_evt cycle=%0d got=%b exp=0", i, evt_valid); end
    end
  endtask

  task automatic test_timeout();
    ev_t got[$];
    ev_t exp[3] = '{'{0, 0, 0}, '{0, 2, 256}, '{0, 1, 300}};
    do_reset();
    evt_ready = 1; enq_ready = '0;
    for (int i = 0; i < 305; i++) begin
      enq_valid = i < 300 ? 4'b0001 : 4'b0000;
      tick();
      if (evt_valid) got.push_back('{int'(evt_slice), int'(evt_kind), int'(evt_wait)});
      if (i == 254) begin
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", timeout_err); end
      end
      if (i == 255) begin
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag got=%b exp=1", timeout_err); end
      end
    end
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL timeout_evt_count got=%0d exp=3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++;
      if (got[k] != exp[k]) begin
        errors++;
        $display("FAIL timeout_evt%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", k, got[k].s, got[k].k, got[k].w, exp[k].s, exp[k].k, exp[k].w);
      end
    end
  endtask

  task automatic test_fifo_fill();
    ev_t got[$];
    ev_t exp[6] = '{'{0, 0, 0}, '{1, 0, 0}, '{2, 0, 0}, '{3, 0, 0}, '{1, 1, 5}, '{2, 1, 5}};
    do_reset();
    evt_ready = 0; enq_valid = 4'hF; enq_ready = '0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({evt_valid, evt_slice, evt_kind, evt_wait, ovf_err} !== {1'b1, 20'd0, 1'b0}) begin
      errors++; $display("FAIL fill_head got=%h ovf=%b exp head=S0 ovf=0", {evt_valid, evt_slice, evt_kind, evt_wait}, ovf_err);
    end
    enq_valid = 4'b1001;
    tick();
    checks++;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL fill_pending_ovf got=%b exp=0", ovf_err); end
    enq_valid = 4'b1011;
    tick();
    checks++;
    if ({evt_valid, evt_slice, evt_kind, evt_wait, ovf_err} !== {1'b1, 20'd0, 1'b1}) begin
      errors++; $display("FAIL fill_ovf got head=%h ovf=%b exp head=S0 ovf=1", {evt_valid, evt_slice, evt_kind, evt_wait}, ovf_err);
    end
    evt_ready = 1;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid) got.push_back('{int'(evt_slice), int'(evt_kind), int'(evt_wait)});
      tick();
    end
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL fill_drain_count got=%0d exp=6", got.size()); end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      checks++;
      if (got[k] != exp[k]) begin
        errors++;
        $display("FAIL fill_order%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", k, got[k].s, got[k].k, got[k].w, exp[k].s, exp[k].k, exp[k].w);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    evt_ready = 1; enq_valid = 4'b0011; enq_ready = 4'b0001;
    tick();
    checks++;
    if ({stall_err, fire_cnt} !== {1'b1, 32'd1}) begin
      errors++; $display("FAIL clear_pre got stall=%b cnt=%0d exp stall=1 cnt=1", stall_err, fire_cnt);
    end
    clear = 1; enq_valid = 4'b1011;
    tick();
    clear = 0;
    checks++;
    if ({stall_err, fire_cnt} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL clear_wins got stall=%b cnt=%0d exp stall=0 cnt=0", stall_err, fire_cnt);
    end
    checks++;
    if ({evt_valid, evt_slice, evt_kind, evt_wait} !== {1'b1, 2'd1, 2'd0, 16'd0}) begin
      errors++; $display("FAIL clear_evt1 got=%h exp=%h", {evt_valid, evt_slice, evt_kind, evt_wait}, {1'b1, 2'd1, 2'd0, 16'd0});
    end
    tick();
    checks++;
    if ({evt_valid, evt_slice, evt_kind, evt_wait} !== {1'b1, 2'd3, 2'd0, 16'd0}) begin
      errors++; $display("FAIL clear_evt3 got=%h exp=%h", {evt_valid, evt_slice, evt_kind, evt_wait}, {1'b1, 2'd3, 2'd0, 16'd0});
    end
    enq_valid = '0; enq_ready = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    evt_ready = 0; enq_valid = 4'b0011; enq_ready = '0;
    tick(); tick(); tick();
    enq_valid = 4'b1011;
    tick();
    checks++;
    if ({evt_valid, stall_err} !== 2'b11) begin
      errors++; $display("FAIL mid_pre got valid,stall=%b exp=11", {evt_valid, stall_err});
    end
    #2;
    rst = 1; enq_valid = '0;
    #1;
    checks++;
    if ({evt_valid, evt_slice, evt_kind, evt_wait, stall_err, timeout_err, ovf_err, fire_cnt} !== 56'd0) begin
      errors++; $display("FAIL mid_async got=%h exp=0", {evt_valid, evt_slice, evt_kind, evt_wait, stall_err, timeout_err, ovf_err, fire_cnt});
    end
    tick();
    rst = 0; evt_ready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({evt_valid, stall_err} !== 2'b00) begin
        errors++; $display("FAIL mid_stale cycle=%0d got valid,stall=%b exp=00", i, {evt_valid, stall_err});
      end
    end
  endtask

  task automatic test_random();
    logic [55:0] got, exp;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NS; i++) if ($urandom_range(3) == 0) enq_valid[i] = ~enq_valid[i];
      enq_ready = 4'($urandom & $urandom);
      evt_ready = n < 1500 ? $urandom_range(3) != 0 : $urandom_range(3) == 0;
      clear = $urandom_range(63) == 0;
      tick();
      got = {evt_valid, evt_slice, evt_kind, evt_wait, stall_err, timeout_err, ovf_err, fire_cnt};
      exp = m_fifo.size() > 0 ? {1'b1, 2'(m_fifo[0].s), 2'(m_fifo[0].k), 16'(m_fifo[0].w), 35'd0} : 56'd0;
      exp[34:0] = {m_stall, m_tmo, m_ovf, 32'(m_fire)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random cycle=%0d got=%h exp=%h", n, got, exp); end
    end
    clear = 0;
  endtask

  initial begin
    test_reset();
    test_stall_fire();
    test_all_fire();
    test_timeout();
    test_fifo_fill();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/probe_enq_monitor.md
# probe_enq_monitor

Synthesizable per-slice monitor for the L2 probe-helper queue enqueue handshakes (`queue_io_enq_valid` / `queue_io_enq_ready`) on all L2 slices. It sits directly downstream of those handshakes and replaces the simulation-only rising-valid/ready property with a cycle-accurate event stream. It classifies each enqueue attempt, measures the wait in cycles, flags protocol violations and starvation, and pushes event records into a small FIFO drained by a valid/ready consumer (trace port or debug CSR).

## Interface
- NUM_SLICES, 4, number of monitored L2 slices (power of two, ≥2)
- TIMEOUT, 256, wait cycles that raise a timeout event (≥2)
- CNT_W, 16, width of per-slice wait counter and `evt_wait`
- FIFO_DEPTH, 4, event FIFO entries (power of two)

- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- enq_valid  in  NUM_SLICES  per-slice probe queue enq valid
- enq_ready  in  NUM_SLICES  per-slice probe queue enq ready
- clear  in  1  synchronous clear of sticky flags and counters; the FIFO is not cleared
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_slice  out  log2(NUM_SLICES)  slice ID of head event
- evt_kind  out  2  0=STALL_ON_RISE, 1=DROP, 2=TIMEOUT, 3=FIRE_AFTER_WAIT
- evt_wait  out  CNT_W  wait cycles recorded with the event
- stall_err  out  1  sticky: any STALL_ON_RISE seen
- timeout_err  out  1  sticky: any TIMEOUT seen
- ovf_err  out  1  sticky: an event was lost
- fire_cnt  out  32  total enqueue handshakes, all slices, saturating

## Operation
- Per slice, a registered `prev_valid` is reset to 0. A rise is `enq_valid & ~prev_valid`. A fire is `enq_valid & enq_ready`.
- Per-slice FSM: IDLE, WAIT, STARVED.
  - IDLE: on rise with ready low, emit STALL_ON_RISE (wait=0), set wait_cnt=1, go to WAIT. On valid with ready low and no rise (valid held from before reset release), go to WAIT without emitting.
  - WAIT: fire → emit FIRE_AFTER_WAIT (wait=wait_cnt), go to IDLE. Valid low → emit DROP (wait=wait_cnt), go to IDLE. Otherwise wait_cnt++; when wait_cnt reaches TIMEOUT, emit TIMEOUT (wait=TIMEOUT) and go to STARVED.
  - STARVED: wait_cnt keeps counting and saturates at 2^CNT_W−1. Fire → FIRE_AFTER_WAIT and IDLE. Valid low → DROP and IDLE.
- A fire in IDLE (zero-wait) emits no event. It only increments `fire_cnt`.
- Each slice has a one-entry pending register. A new event while pending is full is dropped and sets `ovf_err`.
- A round-robin arbiter picks one pending slice per cycle. The pointer advances past the granted slice. Grant requires FIFO space: count<FIFO_DEPTH, or a pop in the same cycle.
- Pending set and grant of the same slice in one cycle: the old entry moves to the FIFO and the new entry is captured. There is no loss.
- `clear`: zeroes `stall_err`, `timeout_err`, `ovf_err`, `fire_cnt`. Clear wins over a same-cycle set or increment. FSMs, pending registers and the FIFO are untouched.
- `fire_cnt` counts the number of fires per cycle (popcount) and saturates at 2^32−1.

## Timing
- Reset values: `evt_valid`=0, `evt_slice`/`evt_kind`/`evt_wait`=0, all sticky flags 0, `fire_cnt`=0, FSMs IDLE, wait_cnt 0, pending empty, FIFO empty, RR pointer 0.
- Event detected in cycle T → pending at T+1 → FIFO write end of T+1 (if granted) → `evt_valid` at T+2. Minimum latency is 2 cycles.
- Sticky flags are set at posedge ending cycle T.
- FIFO head payload is stable while `evt_valid & ~evt_ready`. Pop on `evt_valid & evt_ready`. Push and pop are allowed in the same cycle when full.
- Reset mid-wait discards all in-flight events and counts immediately (asynchronous).

## Test plan
- Slice 2: valid rises with ready low for 3 cycles, then ready=1 → STALL_ON_RISE{slice2,wait0} at T+2, then FIRE_AFTER_WAIT{slice2,wait3}; `stall_err`=1; `fire_cnt`=1.
- All 4 slices: rise and fire in the same cycle, evt_ready=1 → no events; `fire_cnt`=4 next cycle.
- Slice 0: valid held, ready low for 256 cycles → TIMEOUT{0,256}, `timeout_err`=1. Valid then drops at wait 300 → DROP{0,300}.
- All slices emit STALL_ON_RISE in the same cycle, evt_ready=0 → FIFO fills 4 entries in RR order 0,1,2,3. Further events from slices 1 and 2 are held in pending; a third event on slice 1 sets `ovf_err`.
- Assert `clear` in the same cycle as a new stall → `stall_err` remains 0. Event is still delivered.
- Assert reset while 2 events are queued and slice 3 is in WAIT → outputs 0 the same cycle. After release, no stale events appear.
